arcade_input_mapper: RTL and testbench
======================================

// Module: arcade_input_mapper
// PURPOSE
//  Parametrised successor to the per-core keyboard/joystick glue in emu tops: decodes hps_io ps2_key
//  and joystick words into per-player arcade controls for NUM_PLAYERS. Adds per-player autofire,
//  coin pulse stretching with pause freeze, and selectable output polarity. Sits between hps_io and
//  the game top-level; feeds the pause block (pause_btn) and the game inputs.
// PARAMETERS
//  NUM_PLAYERS  2    players, 1..4; keyboard maps exist for P1/P2 only, P3+ are joystick-only
//  CLK_MHZ      49   clk_sys frequency in MHz; ms tick = CLK_MHZ*1000 cycles
//  COIN_MS      100  minimum coin output width in ms, 1..255
//  AF_HALF_MS   33   autofire half-period in ms, 1..255
//  ACTIVE_LOW   1    1: game-side outputs active-low; 0: active-high
// PORTS
//  clk_sys      in   1               system clock
//  reset        in   1               synchronous, active-high
//  ps2_key      in   11              [10] toggle strobe, [9] pressed, [8] extended (ignored), [7:0] scan code
//  joystick     in   16*NUM_PLAYERS  player n at [16n+15:16n]; bit0 R,1 L,2 D,3 U,4 fire,5 start,6 coin,7 pause
//  autofire_en  in   NUM_PLAYERS     per-player autofire enable (OSD)
//  pause        in   1               CPU paused; freezes coin and autofire timers
//  p_dir        out  4*NUM_PLAYERS   player n {down,up,right,left} at [4n+3:4n]
//  p_fire       out  NUM_PLAYERS     fire
//  p_start      out  NUM_PLAYERS     start
//  p_coin       out  NUM_PLAYERS     stretched coin
//  service      out  1               service switch
//  pause_btn    out  1               pause request, always active-high (feeds pause block)
// BEHAVIOUR
//  - Reset: all key latches 0, timers 0, AF phase 1; game outputs inactive (all 1 if ACTIVE_LOW);
//    pause_btn 0. Reset mid-stretch or mid-autofire aborts immediately.
//  - Keyboard: key latch updates when ps2_key[10] differs from its registered copy; latch <= [9].
//    Codes: 16 start1, 1E start2, 2E coin1, 36 coin2, 46 service, 4D pause; P1 75/72/6B/74/14
//    U/D/L/R/fire; P2 1D/1B/1C/23/2A. Unlisted codes ignored. Toggle at same value: no-op.
//  - Raw control n = key latch OR joystick bit. pause_btn = OR of all pause keys/bits.
//  - Latency: ps2_key toggle -> output 2 cycles; joystick change -> output 1 cycle (outputs registered).
//  - ms tick: free-running prescaler, 1-cycle pulse every CLK_MHZ*1000 cycles; prescaler runs during
//    pause but ticks are not consumed by frozen timers.
//  - Coin (per player): states IDLE, STRETCH. IDLE + raw rising edge -> STRETCH, cnt=COIN_MS.
//    STRETCH: decrement on tick when !pause; cnt==0 -> IDLE. p_coin = STRETCH OR raw (held coin
//    stays asserted). Rising edge while in STRETCH ignored (no retrigger). 8-bit counter, no wrap.
//  - Autofire (per player): raw fire && autofire_en -> fire = phase; phase starts 1 on same cycle
//    as press, toggles every AF_HALF_MS ticks while held and !pause. Release -> phase 1, cnt 0.
//    autofire_en low -> fire = raw fire. Enable change mid-hold takes effect next cycle.
//  - Simultaneous keyboard + joystick same control: OR; release of one keeps other active.
// STRUCTURE
//  - Package arcade_input_pkg: scan-code localparams, joystick bit indices, COIN/AF counter width (8).
//  - Sub-module input_timer_ch (one per player): coin FSM + autofire phase, inputs tick/pause/raw.
//  - Top holds ps2 decode, prescaler, OR/polarity output regs.
// TESTING
//  - Reset then idle: ACTIVE_LOW=1 -> p_dir=all 1, p_fire/p_start/p_coin=1, pause_btn=0.
//  - ps2_key toggle with {pressed=1,code=75} -> p_dir[2]=0 exactly 2 cycles later; release toggle -> 1.
//  - joystick[6] pulse 1 cycle, CLK_MHZ=1 (1000-cycle tick) COIN_MS=3 -> p_coin low 3 ticks (+-1 tick), then high.
//  - Coin stretch with pause=1 for 5000 cycles mid-stretch -> p_coin stays low until 3 unpaused ticks elapse.
//  - autofire_en[0]=1, fire held, AF_HALF_MS=2 -> p_fire[0] toggles every 2 ticks, starts active; release -> inactive next cycle.
//  - Keyboard P2 fire + joystick_1 fire overlapping, release keyboard first -> p_fire[1] stays active until joystick release.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: scan codes, joystick bit layout,
// timer widths and the coin FSM state type.
package arcade_input_pkg;

  localparam int CNT_W = 8;

  localparam logic [7:0] SC_START1  = 8'h16;
  localparam logic [7:0] SC_START2  = 8'h1E;
  localparam logic [7:0] SC_COIN1   = 8'h2E;
  localparam logic [7:0] SC_COIN2   = 8'h36;
  localparam logic [7:0] SC_SERVICE = 8'h46;
  localparam logic [7:0] SC_PAUSE   = 8'h4D;

  localparam logic [7:0] SC_P1_UP    = 8'h75;
  localparam logic [7:0] SC_P1_DOWN  = 8'h72;
  localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h74;
  localparam logic [7:0] SC_P1_FIRE  = 8'h14;

  localparam logic [7:0] SC_P2_UP    = 8'h1D;
  localparam logic [7:0] SC_P2_DOWN  = 8'h1B;
  localparam logic [7:0] SC_P2_LEFT  = 8'h1C;
  localparam logic [7:0] SC_P2_RIGHT = 8'h23;
  localparam logic [7:0] SC_P2_FIRE  = 8'h2A;

  localparam int JB_RIGHT = 0;
  localparam int JB_LEFT  = 1;
  localparam int JB_DOWN  = 2;
  localparam int JB_UP    = 3;
  localparam int JB_FIRE  = 4;
  localparam int JB_START = 5;
  localparam int JB_COIN  = 6;
  localparam int JB_PAUSE = 7;

  // Bit positions inside a player's 4-bit p_dir group
  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;

  typedef enum logic {
    COIN_IDLE,
    COIN_STRETCH
  } coin_state_t;

  function automatic logic [3:0] joy_to_dir(input logic [7:0] joy);
    return {joy[JB_DOWN], joy[JB_UP], joy[JB_RIGHT], joy[JB_LEFT]};
  endfunction

endpackage

// File: rtl/input_timer_ch.sv
// Per-player timing channel: coin pulse stretcher FSM and autofire phase generator,
// both frozen while the CPU is paused.
module input_timer_ch
  import arcade_input_pkg::*;
#(
  parameter int COIN_MS    = 100,
  parameter int AF_HALF_MS = 33
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic tick,
  input  logic pause,
  input  logic coin_raw,
  input  logic fire_raw,
  input  logic autofire_en,
  output logic coin_active,
  output logic fire_active
);

  coin_state_t      coin_state_reg;
  logic [CNT_W-1:0] coin_cnt_reg;
  logic             coin_raw_reg;
  logic [CNT_W-1:0] af_cnt_reg;
  logic             af_phase_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      coin_state_reg <= COIN_IDLE;
      coin_cnt_reg   <= '0;
      coin_raw_reg   <= 1'b0;
      af_cnt_reg     <= '0;
      af_phase_reg   <= 1'b1;
    end else begin
      coin_raw_reg <= coin_raw;

      // A rising edge only starts a stretch from IDLE; no retrigger while stretching
      if (coin_state_reg == COIN_IDLE) begin
        if (coin_raw && !coin_raw_reg) begin
          coin_state_reg <= COIN_STRETCH;
          coin_cnt_reg   <= CNT_W'(COIN_MS);
        end
      end else begin
        if (coin_cnt_reg == '0) begin
          coin_state_reg <= COIN_IDLE;
        end else if (tick && !pause) begin
          coin_cnt_reg <= coin_cnt_reg - 1'b1;
        end
      end

      if (!fire_raw) begin
        af_phase_reg <= 1'b1;
        af_cnt_reg   <= '0;
      end else if (tick && !pause) begin
        if (af_cnt_reg == CNT_W'(AF_HALF_MS - 1)) begin
          af_phase_reg <= ~af_phase_reg;
          af_cnt_reg   <= '0;
        end else begin
          af_cnt_reg <= af_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign coin_active = (coin_state_reg == COIN_STRETCH) || coin_raw;
  assign fire_active = fire_raw && (!autofire_en || af_phase_reg);

endmodule

// File: rtl/arcade_input_mapper.sv
// Maps hps_io ps2_key and joystick words onto per-player arcade controls with
// coin stretching, autofire and selectable game-side polarity.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CLK_MHZ     = 49,
  parameter int COIN_MS     = 100,
  parameter int AF_HALF_MS  = 33,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [10:0]               ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joystick,
  input  logic [NUM_PLAYERS-1:0]    autofire_en,
  input  logic                      pause,
  output logic [4*NUM_PLAYERS-1:0]  p_dir,
  output logic [NUM_PLAYERS-1:0]    p_fire,
  output logic [NUM_PLAYERS-1:0]    p_start,
  output logic [NUM_PLAYERS-1:0]    p_coin,
  output logic                      service,
  output logic                      pause_btn
);

  localparam int   TICK_DIV = CLK_MHZ * 1000;
  localparam int   PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic INACTIVE = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0] pre_cnt_reg;
  logic             tick;

  assign tick = (pre_cnt_reg == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset || tick) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + 1'b1;
    end
  end

  logic            strobe_reg;
  logic [1:0][3:0] key_dir_reg;
  logic [1:0]      key_fire_reg;
  logic [1:0]      key_start_reg;
  logic [1:0]      key_coin_reg;
  logic            key_service_reg;
  logic            key_pause_reg;
  logic            pressed;
  logic            unused_ext;

  assign pressed    = ps2_key[9];
  assign unused_ext = ps2_key[8];

  // Strobe copy is loaded from the live input in reset so no phantom event follows reset
  always_ff @(posedge clk_sys) begin
    strobe_reg <= ps2_key[10];
    if (reset) begin
      key_dir_reg     <= '0;
      key_fire_reg    <= '0;
      key_start_reg   <= '0;
      key_coin_reg    <= '0;
      key_service_reg <= 1'b0;
      key_pause_reg   <= 1'b0;
    end else if (ps2_key[10] != strobe_reg) begin
      case (ps2_key[7:0])
        SC_START1:   key_start_reg[0]          <= pressed;
        SC_START2:   key_start_reg[1]          <= pressed;
        SC_COIN1:    key_coin_reg[0]           <= pressed;
        SC_COIN2:    key_coin_reg[1]           <= pressed;
        SC_SERVICE:  key_service_reg           <= pressed;
        SC_PAUSE:    key_pause_reg             <= pressed;
        SC_P1_UP:    key_dir_reg[0][DIR_UP]    <= pressed;
        SC_P1_DOWN:  key_dir_reg[0][DIR_DOWN]  <= pressed;
        SC_P1_LEFT:  key_dir_reg[0][DIR_LEFT]  <= pressed;
        SC_P1_RIGHT: key_dir_reg[0][DIR_RIGHT] <= pressed;
        SC_P1_FIRE:  key_fire_reg[0]           <= pressed;
        SC_P2_UP:    key_dir_reg[1][DIR_UP]    <= pressed;
        SC_P2_DOWN:  key_dir_reg[1][DIR_DOWN]  <= pressed;
        SC_P2_LEFT:  key_dir_reg[1][DIR_LEFT]  <= pressed;
        SC_P2_RIGHT: key_dir_reg[1][DIR_RIGHT] <= pressed;
        SC_P2_FIRE:  key_fire_reg[1]           <= pressed;
        default: ;
      endcase
    end
  end

  logic [4*NUM_PLAYERS-1:0] dir_next;
  logic [NUM_PLAYERS-1:0]   fire_next;
  logic [NUM_PLAYERS-1:0]   start_next;
  logic [NUM_PLAYERS-1:0]   coin_next;
  logic [NUM_PLAYERS-1:0]   pause_raw;

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [7:0] joy;
      logic [3:0] kdir;
      logic       kfire;
      logic       kstart;
      logic       kcoin;
      logic       unused_joy;

      assign joy        = joystick[16*gi +: 8];
      assign unused_joy = ^joystick[16*gi+8 +: 8];

      if (gi < 2) begin : g_kb
        assign kdir   = key_dir_reg[gi];
        assign kfire  = key_fire_reg[gi];
        assign kstart = key_start_reg[gi];
        assign kcoin  = key_coin_reg[gi];
      end else begin : g_no_kb
        assign kdir   = '0;
        assign kfire  = 1'b0;
        assign kstart = 1'b0;
        assign kcoin  = 1'b0;
      end

      assign dir_next[4*gi +: 4] = kdir | joy_to_dir(joy);
      assign start_next[gi]      = kstart | joy[JB_START];
      assign pause_raw[gi]       = joy[JB_PAUSE];

      input_timer_ch #(
        .COIN_MS    (COIN_MS),
        .AF_HALF_MS (AF_HALF_MS)
      ) u_timer (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .tick        (tick),
        .pause       (pause),
        .coin_raw    (kcoin | joy[JB_COIN]),
        .fire_raw    (kfire | joy[JB_FIRE]),
        .autofire_en (autofire_en[gi]),
        .coin_active (coin_next[gi]),
        .fire_active (fire_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      p_dir     <= {(4*NUM_PLAYERS){INACTIVE}};
      p_fire    <= {NUM_PLAYERS{INACTIVE}};
      p_start   <= {NUM_PLAYERS{INACTIVE}};
      p_coin    <= {NUM_PLAYERS{INACTIVE}};
      service   <= INACTIVE;
      pause_btn <= 1'b0;
    end else begin
      p_dir     <= dir_next ^ {(4*NUM_PLAYERS){INACTIVE}};
      p_fire    <= fire_next ^ {NUM_PLAYERS{INACTIVE}};
      p_start   <= start_next ^ {NUM_PLAYERS{INACTIVE}};
      p_coin    <= coin_next ^ {NUM_PLAYERS{INACTIVE}};
      service   <= key_service_reg ^ INACTIVE;
      pause_btn <= key_pause_reg | (|pause_raw);
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: vector table through a scoreboard queue plus
// timed sequences for coin stretch, pause freeze, autofire and key/joystick overlap.
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joystick;
  logic [1:0]  autofire_en;
  logic        pause;
  logic [7:0]  p_dir;
  logic [1:0]  p_fire;
  logic [1:0]  p_start;
  logic [1:0]  p_coin;
  logic        service;
  logic        pause_btn;

  arcade_input_mapper #(
    .NUM_PLAYERS (2),
    .CLK_MHZ     (1),
    .COIN_MS     (3),
    .AF_HALF_MS  (2),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_key     (ps2_key),
    .joystick    (joystick),
    .autofire_en (autofire_en),
    .pause       (pause),
    .p_dir       (p_dir),
    .p_fire      (p_fire),
    .p_start     (p_start),
    .p_coin      (p_coin),
    .service     (service),
    .pause_btn   (pause_btn)
  );

  always #5 clk_sys = ~clk_sys;

  int   checks = 0;
  int   errors = 0;
  logic strobe = 1'b0;

  typedef struct {
    int         id;
    logic [7:0] dir;
    logic [1:0] fire;
    logic [1:0] start;
    logic [1:0] coin;
    logic       service;
    logic       pause_btn;
  } exp_t;

  typedef struct {
    logic [31:0] joy;
    logic [1:0]  af;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[15];

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic range_chk(input string name, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  function automatic exp_t idle_exp(input int id);
    exp_t e;
    e.id = id; e.dir = 8'hFF; e.fire = 2'b11; e.start = 2'b11;
    e.coin = 2'b11; e.service = 1'b1; e.pause_btn = 1'b0;
    return e;
  endfunction

  function automatic vec_t mk(input int id, input logic [31:0] joy, input logic [1:0] af,
                              input logic [7:0] dir, input logic [1:0] fire,
                              input logic [1:0] start, input logic pb);
    vec_t v;
    v.joy = joy; v.af = af;
    v.e = idle_exp(id);
    v.e.dir = dir; v.e.fire = fire; v.e.start = start; v.e.pause_btn = pb;
    return v;
  endfunction

  task automatic check_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = exp_q.pop_front();
    cmp($sformatf("e%0d_dir", e.id), p_dir, e.dir);
    cmp($sformatf("e%0d_fire", e.id), p_fire, e.fire);
    cmp($sformatf("e%0d_start", e.id), p_start, e.start);
    cmp($sformatf("e%0d_coin", e.id), p_coin, e.coin);
    cmp($sformatf("e%0d_service", e.id), service, e.service);
    cmp($sformatf("e%0d_pause_btn", e.id), pause_btn, e.pause_btn);
  endtask

  task automatic expect_after(input exp_t e, input int n);
    exp_q.push_back(e);
    step(n);
    check_pop();
  endtask

  task automatic kb(input logic pressed, input logic [7:0] code);
    strobe  = ~strobe;
    ps2_key = {strobe, pressed, 1'b0, code};
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   low_cnt;
    int   high_cnt;
    int   run_len;
    int   trans;
    int   waited;
    logic prev;

    vecs[0]  = mk(100, 32'h0000_0000, 2'b00, 8'hFF, 2'b11, 2'b11, 1'b0);
    vecs[1]  = mk(101, 32'h0000_0001, 2'b00, 8'hFD, 2'b11, 2'b11, 1'b0);
    vecs[2]  = mk(102, 32'h0000_0002, 2'b00, 8'hFE, 2'b11, 2'b11, 1'b0);
    vecs[3]  = mk(103, 32'h0000_0004, 2'b00, 8'hF7, 2'b11, 2'b11, 1'b0);
    vecs[4]  = mk(104, 32'h0000_0008, 2'b00, 8'hFB, 2'b11, 2'b11, 1'b0);
    vecs[5]  = mk(105, 32'h0008_0000, 2'b00, 8'hBF, 2'b11, 2'b11, 1'b0);
    vecs[6]  = mk(106, 32'h0002_0000, 2'b00, 8'hEF, 2'b11, 2'b11, 1'b0);
    vecs[7]  = mk(107, 32'h0020_0000, 2'b00, 8'hFF, 2'b11, 2'b01, 1'b0);
    vecs[8]  = mk(108, 32'h0000_0020, 2'b00, 8'hFF, 2'b11, 2'b10, 1'b0);
    vecs[9]  = mk(109, 32'h0000_0010, 2'b00, 8'hFF, 2'b10, 2'b11, 1'b0);
    vecs[10] = mk(110, 32'h0080_0000, 2'b00, 8'hFF, 2'b11, 2'b11, 1'b1);
    vecs[11] = mk(111, 32'h0000_FF00, 2'b00, 8'hFF, 2'b11, 2'b11, 1'b0);
    vecs[12] = mk(112, 32'h0000_0009, 2'b00, 8'hF9, 2'b11, 2'b11, 1'b0);
    vecs[13] = mk(113, 32'h0010_0000, 2'b10, 8'hFF, 2'b01, 2'b11, 1'b0);
    vecs[14] = mk(114, 32'h0000_0080, 2'b00, 8'hFF, 2'b11, 2'b11, 1'b1);

    reset = 1'b1; ps2_key = '0; joystick = '0; autofire_en = '0; pause = 1'b0;
    step(3);
    cmp("reset_dir", p_dir, 8'hFF);
    cmp("reset_pause_btn", pause_btn, 1'b0);
    reset = 1'b0;
    expect_after(idle_exp(0), 1);

    for (int i = 0; i < 15; i++) begin
      joystick    = vecs[i].joy;
      autofire_en = vecs[i].af;
      expect_after(vecs[i].e, 1);
    end
    joystick = '0; autofire_en = '0;
    step(2);

    // Keyboard: two-cycle latency, release, same-value toggle, service, pause, unlisted code
    e = idle_exp(1); e.dir = 8'hFB;
    kb(1'b1, 8'h75);
    expect_after(idle_exp(2), 1);
    expect_after(e, 1);
    kb(1'b0, 8'h75);
    e.id = 3;
    expect_after(e, 1);
    expect_after(idle_exp(4), 1);
    kb(1'b0, 8'h75);
    expect_after(idle_exp(5), 2);
    e = idle_exp(6); e.service = 1'b0;
    kb(1'b1, 8'h46);
    expect_after(e, 2);
    kb(1'b0, 8'h46);
    expect_after(idle_exp(7), 2);
    e = idle_exp(8); e.pause_btn = 1'b1;
    kb(1'b1, 8'h4D);
    expect_after(e, 2);
    kb(1'b0, 8'h4D);
    expect_after(idle_exp(9), 2);
    kb(1'b1, 8'h55);
    expect_after(idle_exp(10), 2);
    e = idle_exp(11); e.start = 2'b01;
    kb(1'b1, 8'h1E);
    expect_after(e, 2);
    kb(1'b0, 8'h1E);
    expect_after(idle_exp(12), 2);

    // Single-cycle coin pulse is stretched to about COIN_MS ticks
    joystick[6] = 1'b1;
    step(1);
    cmp("coin_immediate", p_coin[0], 1'b0);
    joystick[6] = 1'b0;
    low_cnt = 1;
    while (p_coin[0] == 1'b0 && low_cnt < 10000) begin
      step(1);
      low_cnt++;
    end
    range_chk("coin_stretch_len", low_cnt, 2000, 4000);
    cmp("coin_p2_idle", p_coin[1], 1'b1);

    // Held coin stays asserted beyond the stretch
    joystick[6] = 1'b1;
    high_cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      step(1);
      if (p_coin[0] == 1'b1) high_cnt++;
    end
    cmp("coin_held_highs", high_cnt, 0);
    joystick[6] = 1'b0;
    step(1);
    cmp("coin_held_release", p_coin[0], 1'b1);
    step(10);

    // Pause mid-stretch freezes the coin counter
    joystick[6] = 1'b1;
    step(1);
    joystick[6] = 1'b0;
    low_cnt = 1;
    high_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (p_coin[0] == 1'b1) high_cnt++;
      low_cnt++;
    end
    pause = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      step(1);
      if (p_coin[0] == 1'b1) high_cnt++;
    end
    cmp("coin_pause_highs", high_cnt, 0);
    pause = 1'b0;
    while (p_coin[0] == 1'b0 && low_cnt < 10000) begin
      step(1);
      low_cnt++;
    end
    range_chk("coin_unpaused_len", low_cnt, 2000, 4000);

    // Reset mid-stretch aborts it
    joystick[6] = 1'b1;
    step(1);
    joystick[6] = 1'b0;
    step(100);
    cmp("coin_before_reset", p_coin[0], 1'b0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    cmp("coin_in_reset", p_coin[0], 1'b1);
    step(1);
    cmp("coin_after_reset", p_coin[0], 1'b1);

    // Autofire: starts active, half-period of 2 ticks = 2000 cycles
    autofire_en = 2'b01;
    joystick[4] = 1'b1;
    step(1);
    cmp("af_start_active", p_fire[0], 1'b0);
    prev = p_fire[0];
    run_len = 1;
    trans = 0;
    for (int i = 0; i < 9000; i++) begin
      step(1);
      if (p_fire[0] != prev) begin
        if (trans > 0) cmp($sformatf("af_run%0d", trans), run_len, 2000);
        trans++;
        run_len = 1;
        prev = p_fire[0];
      end else begin
        run_len++;
      end
    end
    range_chk("af_transitions", trans, 4, 5);
    cmp("af_p2_idle", p_fire[1], 1'b1);

    waited = 0;
    while (p_fire[0] != 1'b1 && waited < 5000) begin
      step(1);
      waited++;
    end
    cmp("af_wait_off_phase", p_fire[0], 1'b1);
    autofire_en = 2'b00;
    step(1);
    cmp("af_disable_midhold", p_fire[0], 1'b0);
    autofire_en = 2'b01;
    joystick[4] = 1'b0;
    step(1);
    cmp("af_release", p_fire[0], 1'b1);
    joystick[4] = 1'b1;
    step(1);
    cmp("af_repress_active", p_fire[0], 1'b0);
    joystick[4] = 1'b0;
    autofire_en = 2'b00;
    step(2);

    // Keyboard P2 fire and joystick P2 fire overlap
    kb(1'b1, 8'h2A);
    step(2);
    cmp("ovl_kb_fire", p_fire[1], 1'b0);
    joystick[20] = 1'b1;
    step(1);
    cmp("ovl_both_fire", p_fire[1], 1'b0);
    kb(1'b0, 8'h2A);
    step(2);
    cmp("ovl_kb_released", p_fire[1], 1'b0);
    joystick[20] = 1'b0;
    step(1);
    cmp("ovl_all_released", p_fire[1], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
